// File: rtl/k005297_pgconv_abs2rel.sv
// Bit-serial absolute->relative page converter: three serial adders pick the relative page,
// which is latched at step PGW and replayed LSB-first during the next rotation.
module k005297_pgconv_abs2rel #(
  parameter int PGW      = 12,
  parameter int SPLIT    = 754,
  parameter int WRAP     = 1299,
  parameter int PG_COUNT = 2053
) (
  input  logic           i_MCLK,
  input  logic           i_RST_n,
  input  logic           i_CLK2M_PCEN_n,
  input  logic [19:0]    i_ROT20_n,
  input  logic           i_CONV_EN,
  input  logic           i_ABSPGCNTR_LSB,
  output logic           o_RELPG_LSB,
  output logic [PGW-1:0] o_RELPG,
  output logic           o_VALID,
  output logic           o_RANGE_ERR
);

  localparam logic [PGW-1:0] K_A = PGW'(WRAP);
  localparam logic [PGW-1:0] K_S = PGW'((1 << PGW) - SPLIT);
  localparam logic [PGW-1:0] K_E = PGW'((1 << PGW) - PG_COUNT);

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [PGW-1:0] step_in;
  logic           in_phase, st_first, st_latch, st_clr, any_step, adv;
  logic           k_a_bit, k_s_bit, k_e_bit;

  logic           carry_a_q, carry_a_d;
  logic           carry_s_q, carry_s_d;
  logic           carry_e_q, carry_e_d;
  logic [PGW-1:0] cap_a_q, cap_a_d;
  logic [PGW-1:0] cap_s_q, cap_s_d;
  logic           en_ok_q, en_ok_d;
  logic [PGW-1:0] outsr_q, outsr_d;
  logic [PGW-1:0] relpg_q, relpg_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic [PGW-1:0] result;

  assign step_in  = ~i_ROT20_n[PGW-1:0];
  assign in_phase = |step_in;
  assign st_first = ~i_ROT20_n[0];
  assign st_latch = ~i_ROT20_n[PGW];
  assign st_clr   = ~i_ROT20_n[19];
  assign any_step = ~&i_ROT20_n;
  assign adv      = ~i_CLK2M_PCEN_n & any_step;

  // Constant bit k selected by the one-hot step, so no step counter is needed.
  assign k_a_bit = |(step_in & K_A);
  assign k_s_bit = |(step_in & K_S);
  assign k_e_bit = |(step_in & K_E);

  assign result = carry_e_q ? '0 : (carry_s_q ? cap_s_q : cap_a_q);

  always_comb begin
    carry_a_d = carry_a_q;
    carry_s_d = carry_s_q;
    carry_e_d = carry_e_q;
    cap_a_d   = cap_a_q;
    cap_s_d   = cap_s_q;
    en_ok_d   = en_ok_q;
    outsr_d   = outsr_q;
    relpg_d   = relpg_q;
    valid_d   = valid_q;
    err_d     = err_q;

    if (in_phase) begin
      carry_a_d = fa_carry(i_ABSPGCNTR_LSB, k_a_bit, carry_a_q);
      carry_s_d = fa_carry(i_ABSPGCNTR_LSB, k_s_bit, carry_s_q);
      carry_e_d = fa_carry(i_ABSPGCNTR_LSB, k_e_bit, carry_e_q);
      cap_a_d   = {fa_sum(i_ABSPGCNTR_LSB, k_a_bit, carry_a_q), cap_a_q[PGW-1:1]};
      cap_s_d   = {fa_sum(i_ABSPGCNTR_LSB, k_s_bit, carry_s_q), cap_s_q[PGW-1:1]};
      en_ok_d   = st_first ? i_CONV_EN : (en_ok_q & i_CONV_EN);
      outsr_d   = outsr_q >> 1;
    end

    // Final S carry means abspg >= SPLIT; final E carry means abspg is out of range.
    if (st_latch) begin
      if (en_ok_q) begin
        relpg_d = result;
        outsr_d = result;
        valid_d = 1'b1;
        err_d   = carry_e_q;
      end else begin
        valid_d = 1'b0;
        err_d   = 1'b0;
      end
    end

    if (st_clr) begin
      carry_a_d = 1'b0;
      carry_s_d = 1'b0;
      carry_e_d = 1'b0;
    end
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      carry_a_q <= 1'b0;
      carry_s_q <= 1'b0;
      carry_e_q <= 1'b0;
      cap_a_q   <= '0;
      cap_s_q   <= '0;
      en_ok_q   <= 1'b0;
      outsr_q   <= '0;
      relpg_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else if (adv) begin
      carry_a_q <= carry_a_d;
      carry_s_q <= carry_s_d;
      carry_e_q <= carry_e_d;
      cap_a_q   <= cap_a_d;
      cap_s_q   <= cap_s_d;
      en_ok_q   <= en_ok_d;
      outsr_q   <= outsr_d;
      relpg_q   <= relpg_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign o_RELPG_LSB = outsr_q[0];
  assign o_RELPG     = relpg_q;
  assign o_VALID     = valid_q;
  assign o_RANGE_ERR = err_q;

endmodule

// File: tb/tb_k005297_pgconv_abs2rel.sv
// Scoreboard bench for the absolute->relative page converter.
module tb_k005297_pgconv_abs2rel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcen_n;
  logic [19:0] rot_n;
  logic        conv;
  logic        abs_b;
  logic        relpg_lsb;
  logic [11:0] relpg;
  logic        valid;
  logic        rerr;

  always #5 clk = ~clk;

  k005297_pgconv_abs2rel dut (
    .i_MCLK          (clk),
    .i_RST_n         (rst_n),
    .i_CLK2M_PCEN_n  (pcen_n),
    .i_ROT20_n       (rot_n),
    .i_CONV_EN       (conv),
    .i_ABSPGCNTR_LSB (abs_b),
    .o_RELPG_LSB     (relpg_lsb),
    .o_RELPG         (relpg),
    .o_VALID         (valid),
    .o_RANGE_ERR     (rerr)
  );

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [11:0] relpg;
  } exp_t;

  exp_t        sb[$];
  exp_t        popped;
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [11:0] model_relpg = '0;
  logic [11:0] exp_ser = '0;
  logic        latch_edge = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: page mapping by plain arithmetic; aborted words keep the old parallel value.
  function automatic exp_t model(input int abspg, input bit ok);
    exp_t e;
    if (!ok) begin
      e.valid = 1'b0;
      e.err   = 1'b0;
      e.relpg = model_relpg;
    end else if (abspg >= 2053) begin
      e.valid = 1'b1;
      e.err   = 1'b1;
      e.relpg = 12'd0;
      model_relpg = 12'd0;
    end else begin
      e.valid = 1'b1;
      e.err   = 1'b0;
      e.relpg = (abspg < 754) ? 12'(abspg + 1299) : 12'(abspg - 754);
      model_relpg = e.relpg;
    end
    return e;
  endfunction

  always @(posedge clk) latch_edge <= rst_n && !pcen_n && !rot_n[12];

  // Monitor: parallel result after each latch edge, serial bit during each output step.
  always @(negedge clk) begin
    if (rst_n) begin
      if (latch_edge) begin
        if (sb.size() == 0) begin
          check("unexpected_latch", 1, 0);
        end else begin
          popped = sb.pop_front();
          check("valid", int'(valid), int'(popped.valid));
          check("range_err", int'(rerr), int'(popped.err));
          check("relpg", int'(relpg), int'(popped.relpg));
          exp_ser = popped.valid ? popped.relpg : 12'd0;
        end
      end
      if (!pcen_n) begin
        for (int k = 0; k < 12; k++) begin
          if (!rot_n[k]) check($sformatf("serial_b%0d", k), int'(relpg_lsb), int'(exp_ser[k]));
        end
      end
    end
  end

  task automatic drive(input logic [19:0] r, input logic p, input logic a, input logic c);
    @(posedge clk);
    #1;
    rot_n  = r;
    pcen_n = p;
    abs_b  = a;
    conv   = c;
  endtask

  task automatic idle(input int n);
    repeat (n) drive('1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rotation(input int abspg, input int drop = -1, input bit stall = 0,
                          input int start = 0);
    logic [11:0] a;
    bit          ok;
    bit          en;
    a = abspg[11:0];
    for (int k = start; k < 20; k++) begin
      en = (drop < 0) || (k < drop);
      if (stall && k == 6) repeat (3) drive(rot_n, 1'b1, abs_b, conv);
      drive(~(20'd1 << k), 1'b0, (k < 12) ? a[k] : 1'b0, en);
      if (k == 12) begin
        ok = (start == 0) && (drop < 0 || drop >= 12);
        sb.push_back(model(abspg, ok));
      end
    end
  endtask

  task automatic reset_mid(input int abspg);
    logic [11:0] a;
    a = abspg[11:0];
    for (int k = 0; k < 7; k++) drive(~(20'd1 << k), 1'b0, a[k], 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rot_n = '1;
    #1;
    check("rst_mid_lsb", int'(relpg_lsb), 0);
    check("rst_mid_relpg", int'(relpg), 0);
    check("rst_mid_valid", int'(valid), 0);
    check("rst_mid_err", int'(rerr), 0);
    model_relpg = '0;
    exp_ser     = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    rotation(abspg, -1, 0, 8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int bnd[8] = '{0, 753, 754, 2052, 2053, 4095, 1, 1298};
  int pg, drp;

  initial begin
    rst_n  = 1'b0;
    rot_n  = '1;
    pcen_n = 1'b1;
    abs_b  = 1'b0;
    conv   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_lsb", int'(relpg_lsb), 0);
    check("reset_relpg", int'(relpg), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_err", int'(rerr), 0);
    rst_n = 1'b1;
    idle(2);

    rotation(0);
    rotation(5);
    rotation(753);
    rotation(754);
    rotation(2052);
    rotation(2053);
    rotation(4095);
    rotation(1);
    rotation(100, 5);
    rotation(100);
    idle(2);
    reset_mid(300);
    rotation(300);
    rotation(1500, -1, 1);
    rotation(1500);
    rotation(42, 0);
    rotation(42, 11);

    for (int i = 0; i < 40; i++) begin
      pg  = ($urandom % 4 == 0) ? bnd[$urandom % 8] : int'($urandom_range(0, 4095));
      drp = ($urandom % 8 == 0) ? int'($urandom_range(0, 15)) : -1;
      rotation(pg, drp, ($urandom % 4) == 0);
      if ($urandom % 3 == 0) idle($urandom_range(1, 3));
    end

    rotation(0);
    idle(3);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
